// File: rtl/layer_result_buffer.sv
// layer_result_buffer: on-chip store for one layer's output feature map.
// Written by the PE array as (row, col) results, read back by the next layer's
// fetch logic with one cycle of latency. Includes a sequential clear engine,
// a sticky address-range error flag and a frame-complete pulse.
module layer_result_buffer #(
    parameter  int DATA_W   = 128,
    parameter  int ROW_W    = 14,
    parameter  int NUM_ROWS = 14,
    localparam int DEPTH    = ROW_W * NUM_ROWS,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_start,
    input  logic              save_enable,
    input  logic [DATA_W-1:0] save_data,
    input  logic [15:0]       save_row_addr,
    input  logic [15:0]       save_col_addr,
    input  logic              read_signal,
    input  logic [15:0]       read_row_addr,
    input  logic [15:0]       read_col_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              busy,
    output logic              addr_error,
    output logic              frame_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_error_q, addr_error_d;
    logic                frame_full_q, frame_full_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [31:0]         wr_lin, rd_lin;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic                wr_in_range, rd_in_range;
    logic                wr_accept;
    logic                unused_lin_bits;

    // Linearise addresses at full 32-bit width; range is judged per field so
    // an oversized column can never alias into the following row.
    assign wr_lin      = 32'(save_row_addr) * 32'(ROW_W) + 32'(save_col_addr);
    assign rd_lin      = 32'(read_row_addr) * 32'(ROW_W) + 32'(read_col_addr);
    assign wr_in_range = (32'(save_row_addr) < 32'(NUM_ROWS)) && (32'(save_col_addr) < 32'(ROW_W));
    assign rd_in_range = (32'(read_row_addr) < 32'(NUM_ROWS)) && (32'(read_col_addr) < 32'(ROW_W));
    assign wr_addr     = wr_lin[ADDR_W-1:0];
    assign rd_addr     = rd_lin[ADDR_W-1:0];
    assign unused_lin_bits = ^{wr_lin[31:ADDR_W], rd_lin[31:ADDR_W]};

    // A PE write lands only when idle, in range, and not colliding with a clear request.
    assign wr_accept = (state_q == IDLE) && !clear_start && save_enable && wr_in_range;

    // Next-state logic for the clear FSM, write counter, read port and flags.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        addr_error_d = addr_error_q;
        frame_full_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr;
        mem_wdata    = save_data;

        case (state_q)
            IDLE: begin
                if (read_signal) begin
                    rd_valid_d = 1'b1;
                    if (rd_in_range) begin
                        if (wr_accept && (wr_addr == rd_addr)) begin
                            rd_data_d = save_data;
                        end else begin
                            rd_data_d = mem[rd_addr];
                        end
                    end else begin
                        rd_data_d    = '0;
                        addr_error_d = 1'b1;
                    end
                end

                if (clear_start) begin
                    state_d      = CLEAR;
                    clr_cnt_d    = '0;
                    wr_cnt_d     = '0;
                    addr_error_d = 1'b0;
                end else if (save_enable) begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                        if (wr_cnt_q == CNT_W'(DEPTH - 1)) begin
                            wr_cnt_d     = '0;
                            frame_full_d = 1'b1;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end else begin
                        addr_error_d = 1'b1;
                    end
                end
            end

            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            addr_error_q <= 1'b0;
            frame_full_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            addr_error_q <= addr_error_d;
            frame_full_q <= frame_full_d;
        end
    end

    // Storage array behaves like SRAM: no reset, zeroed only by the clear engine.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
    assign busy       = (state_q == CLEAR);
    assign addr_error = addr_error_q;
    assign frame_full = frame_full_q;

endmodule

// File: tb/tb_layer_result_buffer.sv
// tb_layer_result_buffer: directed, table-driven bench for layer_result_buffer
// using the default 14x14, 128-bit configuration.
module tb_layer_result_buffer;

    localparam int DEPTH = 196;

    logic         clk;
    logic         rst;
    logic         clearStart;
    logic         saveEnable;
    logic [127:0] saveData;
    logic [15:0]  saveRow;
    logic [15:0]  saveCol;
    logic         readSignal;
    logic [15:0]  readRow;
    logic [15:0]  readCol;
    logic [127:0] readData;
    logic         readValid;
    logic         busy;
    logic         addrError;
    logic         frameFull;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        logic         saveEn;
        logic [127:0] data;
        logic [15:0]  sRow;
        logic [15:0]  sCol;
        logic         readEn;
        logic [15:0]  rRow;
        logic [15:0]  rCol;
        logic         expValid;
        logic [127:0] expData;
        logic         expErr;
        logic         expFull;
    } vec_t;

    vec_t vecs [12];

    localparam logic [127:0] VAL_A = {4{32'hA1A1_0001}};
    localparam logic [127:0] VAL_B = {4{32'hB2B2_0002}};
    localparam logic [127:0] VAL_C = {4{32'hC3C3_0003}};
    localparam logic [127:0] VAL_X = {4{32'h5A5A_0004}};
    localparam logic [127:0] VAL_D = {4{32'hDEAD_0005}};
    localparam logic [127:0] VAL_F = {4{32'hFACE_0006}};

    layer_result_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .clear_start  (clearStart),
        .save_enable  (saveEnable),
        .save_data    (saveData),
        .save_row_addr(saveRow),
        .save_col_addr(saveCol),
        .read_signal  (readSignal),
        .read_row_addr(readRow),
        .read_col_addr(readCol),
        .read_data    (readData),
        .read_valid   (readValid),
        .busy         (busy),
        .addr_error   (addrError),
        .frame_full   (frameFull)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the rising edge take them, sample 1 ns later.
    task automatic applyStimulus(input logic se, input logic [127:0] sd,
                                 input logic [15:0] sr, input logic [15:0] sc,
                                 input logic re, input logic [15:0] rr,
                                 input logic [15:0] rc, input logic cs);
        saveEnable = se;
        saveData   = sd;
        saveRow    = sr;
        saveCol    = sc;
        readSignal = re;
        readRow    = rr;
        readCol    = rc;
        clearStart = cs;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        int busyCycles;
        logic pendingBusy;

        // saveEn data sRow sCol readEn rRow rCol expValid expData expErr expFull
        vecs[0]  = '{1'b1, VAL_A, 16'd0,  16'd0,  1'b0, 16'd0,  16'd0,  1'b0, '0,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, VAL_B, 16'd13, 16'd13, 1'b0, 16'd0,  16'd0,  1'b0, '0,    1'b0, 1'b0};
        vecs[2]  = '{1'b0, '0,    16'd0,  16'd0,  1'b1, 16'd0,  16'd0,  1'b1, VAL_A, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, '0,    16'd0,  16'd0,  1'b1, 16'd13, 16'd13, 1'b1, VAL_B, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, '0,    16'd0,  16'd0,  1'b0, 16'd0,  16'd0,  1'b0, VAL_B, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, VAL_C, 16'd2,  16'd0,  1'b0, 16'd0,  16'd0,  1'b0, VAL_B, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, VAL_X, 16'd2,  16'd5,  1'b1, 16'd2,  16'd5,  1'b1, VAL_X, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, VAL_D, 16'd1,  16'd14, 1'b0, 16'd0,  16'd0,  1'b0, VAL_X, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, '0,    16'd0,  16'd0,  1'b1, 16'd2,  16'd0,  1'b1, VAL_C, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, '0,    16'd0,  16'd0,  1'b1, 16'd14, 16'd0,  1'b1, '0,    1'b1, 1'b0};
        vecs[10] = '{1'b0, '0,    16'd0,  16'd0,  1'b1, 16'd0,  16'd0,  1'b1, VAL_A, 1'b1, 1'b0};
        vecs[11] = '{1'b0, '0,    16'd0,  16'd0,  1'b0, 16'd0,  16'd0,  1'b0, VAL_A, 1'b1, 1'b0};

        rst = 1'b0;
        clearStart = 1'b0; saveEnable = 1'b0; saveData = '0; saveRow = '0; saveCol = '0;
        readSignal = 1'b0; readRow = '0; readCol = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_read_data",  readData,  '0);
        checkOutput("reset_read_valid", 128'(readValid), '0);
        checkOutput("reset_busy",       128'(busy),      '0);
        checkOutput("reset_addr_error", 128'(addrError), '0);
        checkOutput("reset_frame_full", 128'(frameFull), '0);
        @(negedge clk);
        rst = 1'b1;

        // Table: basic writes, reads, write-first collision, range errors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].saveEn, vecs[i].data, vecs[i].sRow, vecs[i].sCol,
                          vecs[i].readEn, vecs[i].rRow, vecs[i].rCol, 1'b0);
            checkOutput($sformatf("vec%0d_valid", i), 128'(readValid), 128'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_data", i),  readData,        vecs[i].expData);
            checkOutput($sformatf("vec%0d_err", i),   128'(addrError), 128'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_full", i),  128'(frameFull), 128'(vecs[i].expFull));
        end

        // Clear request with a simultaneous write: write dropped, clear runs DEPTH cycles.
        applyStimulus(1'b1, VAL_D, 16'd3, 16'd3, 1'b0, 16'd0, 16'd0, 1'b1);
        checkOutput("clear_busy_start", 128'(busy),      128'(1'b1));
        checkOutput("clear_err_reset",  128'(addrError), '0);
        busyCycles = 1;
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b1, 16'd0, 16'd0, 1'b0);
        checkOutput("clear_read_valid", 128'(readValid), '0);
        checkOutput("clear_read_hold",  readData,        VAL_A);
        pendingBusy = busy;
        for (int n = 0; n < 400 && pendingBusy; n++) begin
            busyCycles++;
            idleCycle();
            pendingBusy = busy;
        end
        checkOutput("clear_busy_cycles", 128'(busyCycles), 128'(DEPTH));
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b1, 16'd0, 16'd0, 1'b0);
        checkOutput("post_clear_00",    readData,        '0);
        checkOutput("post_clear_valid", 128'(readValid), 128'(1'b1));
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b1, 16'd13, 16'd13, 1'b0);
        checkOutput("post_clear_1313",  readData,        '0);
        checkOutput("post_clear_err",   128'(addrError), '0);

        // Fill the whole frame: frame_full pulses only on the 196th write.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, {96'hF00D, 32'(i)}, 16'(i / 14), 16'(i % 14),
                          1'b0, 16'd0, 16'd0, 1'b0);
            checkOutput($sformatf("fill%0d_full", i), 128'(frameFull), 128'(i == DEPTH - 1));
        end
        applyStimulus(1'b1, VAL_A, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        checkOutput("write197_full", 128'(frameFull), '0);
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b1, 16'd5, 16'd7, 1'b0);
        checkOutput("fill_read_5_7", readData, {96'hF00D, 32'd77});

        // Counter restarted: 195 more writes (same address) complete the next frame.
        for (int j = 0; j < DEPTH - 1; j++) begin
            applyStimulus(1'b1, VAL_B, 16'd13, 16'd13, 1'b0, 16'd0, 16'd0, 1'b0);
            checkOutput($sformatf("refill%0d_full", j), 128'(frameFull), 128'(j == DEPTH - 2));
        end

        // Out-of-range write sets the flag before the reset test.
        applyStimulus(1'b1, VAL_D, 16'd20, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        checkOutput("pre_reset_err", 128'(addrError), 128'(1'b1));

        // Reset asserted mid-clear clears all outputs without a clock edge.
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b1);
        repeat (49) idleCycle();
        checkOutput("midclear_busy", 128'(busy), 128'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_data",  readData,        '0);
        checkOutput("async_rst_valid", 128'(readValid), '0);
        checkOutput("async_rst_busy",  128'(busy),      '0);
        checkOutput("async_rst_err",   128'(addrError), '0);
        checkOutput("async_rst_full",  128'(frameFull), '0);
        @(negedge clk);
        rst = 1'b1;
        idleCycle();
        checkOutput("after_rst_busy", 128'(busy), '0);
        applyStimulus(1'b1, VAL_F, 16'd4, 16'd4, 1'b0, 16'd0, 16'd0, 1'b0);
        applyStimulus(1'b0, '0, 16'd0, 16'd0, 1'b1, 16'd4, 16'd4, 1'b0);
        checkOutput("after_rst_data",  readData,        VAL_F);
        checkOutput("after_rst_valid", 128'(readValid), 128'(1'b1));
        idleCycle();
        checkOutput("after_rst_valid_drop", 128'(readValid), '0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/layer_result_buffer.md
Name: layer_result_buffer

Overview:
- Parametrised on-chip buffer for one layer's output feature map, addressed by (row, col).
- Sits between a layer's PE array, which writes results, and the next layer's fetch logic, which reads them.
- Generalises the fixed 14-wide, 128-bit layer result store with:
  - configurable data width, row stride and row count;
  - registered reads with a valid strobe;
  - an address-range error flag;
  - a frame-complete pulse;
  - a sequential clear engine.

Parameters:
- DATA_W, 128, width of one stored result word.
- ROW_W, 14, entries per row; row stride for address linearisation.
- NUM_ROWS, 14, number of rows.
- DEPTH, ROW_W*NUM_ROWS, total entries (derived; do not override).
- ADDR_W, $clog2(DEPTH), width of the internal linear address (derived).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear_start  input  1  one-cycle request to zero all entries.
- save_enable  input  1  write strobe.
- save_data  input  DATA_W  write data.
- save_row_addr  input  16  write row index.
- save_col_addr  input  16  write column index.
- read_signal  input  1  read request.
- read_row_addr  input  16  read row index.
- read_col_addr  input  16  read column index.
- read_data  output  DATA_W  registered read data.
- read_valid  output  1  high for one cycle when read_data carries the response to a read.
- busy  output  1  clear in progress.
- addr_error  output  1  sticky out-of-range flag.
- frame_full  output  1  one-cycle pulse when DEPTH writes have been accepted.

Behaviour:
- Reset (rst low, asynchronous): read_data=0, read_valid=0, busy=0, addr_error=0, frame_full=0, write counter=0, FSM=IDLE. Memory contents are not reset (SRAM-like); the clear engine zeroes them.
- Address mapping: linear = row*ROW_W + col, computed at full width, ≥ 32 bits.
  - In range only when row < NUM_ROWS and col < ROW_W.
  - No truncation or wrap: an out-of-range col must never alias into the next row.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_start.
  - CLEAR writes 0 to entry clr_cnt each cycle, for clr_cnt = 0 to DEPTH-1.
  - CLEAR -> IDLE after entry DEPTH-1 is written, so the clear takes exactly DEPTH cycles.
  - busy is high for every cycle the FSM is in CLEAR.
  - clear_start while busy is ignored.
  - Entering CLEAR resets the write counter to 0 and clears addr_error.
- Write (IDLE only): on an edge with save_enable=1 and an in-range address, mem[linear] <= save_data and the write counter increments.
  - Out-of-range write: dropped; addr_error <= 1.
  - save_enable during CLEAR, or in the same cycle as an accepted clear_start: dropped silently; no error.
- frame_full:
  - When the counter would reach DEPTH, frame_full pulses for one cycle, registered on the same edge as the final write.
  - The counter returns to 0.
  - Counting is of accepted writes, not distinct addresses.
- Read (IDLE only): read_signal sampled at edge N.
  - read_data and read_valid update at edge N, so data is visible in cycle N+1 (latency 1).
  - read_valid is high for exactly one cycle per request.
  - Back-to-back requests give back-to-back valid responses.
- Out-of-range read: read_data <= 0, read_valid <= 1, addr_error <= 1.
- No request, or request during CLEAR: read_valid <= 0; read_data holds its previous value.
- Simultaneous write and read of the same in-range address in IDLE: write-first; read_data returns save_data from that cycle.
- addr_error remains set until reset or the next clear.
- Reset asserted mid-clear: FSM returns to IDLE immediately and busy drops. Memory is partially cleared; its contents are unspecified.

Test Plan:
- Write (r=0,c=0)=A and (r=13,c=13)=B, then read both: read_data=A then B, each one cycle after its request; read_valid high for 2 consecutive cycles. Linear addresses are 0 and 195.
- Write (r=2,c=5)=X while reading (2,5) in the same cycle: read_data=X next cycle (write-first).
- Write to (r=1,c=14): no entry changes (verify (2,0) unchanged); addr_error=1 and stays 1. Read (14,0): read_data=0, read_valid=1.
- Issue 196 accepted writes: frame_full pulses exactly once, on the edge of write 196. Write 197 gives no pulse; the counter restarts.
- Pulse clear_start with save_enable=1 in the same cycle: the write is dropped, busy is high for 196 cycles, and a read during busy gives read_valid=0. After the clear, a read of any entry returns 0 and addr_error=0.
- Assert rst low 50 cycles into a clear: all outputs are 0 asynchronously. After release, busy=0 and a normal write/read round trip works.
